// File: rtl/branch_pkg.sv
// Shared types for the execute-stage branch resolver.
//  branch_type_e : funct3 codes of the six conditional branches
//  bht_ctr_t     : 2-bit saturating predictor counter, SNT/WNT/WT/ST
//  ctrNext       : saturating counter step toward the resolved direction
package branch_pkg;

  typedef enum logic [2:0] {
    BEQ  = 3'b000,
    BNE  = 3'b001,
    BLT  = 3'b100,
    BGE  = 3'b101,
    BLTU = 3'b110,
    BGEU = 3'b111
  } branch_type_e;

  typedef logic [1:0] bht_ctr_t;

  localparam bht_ctr_t SNT = 2'b00;
  localparam bht_ctr_t WNT = 2'b01;
  localparam bht_ctr_t WT  = 2'b10;
  localparam bht_ctr_t ST  = 2'b11;

  localparam bht_ctr_t BHT_RESET_VAL = WNT;

  // Move one step toward the resolved direction, clamping at SNT/ST.
  function automatic bht_ctr_t ctrNext(input bht_ctr_t ctr, input logic taken);
    bht_ctr_t res;
    res = ctr;
    if (taken) begin
      if (ctr != ST) res = ctr + 2'd1;
    end else begin
      if (ctr != SNT) res = ctr - 2'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/branch_history_table.sv
// PC-indexed table of 2-bit predictor counters.
//  clk, reset : clock, synchronous active-high reset (all entries -> WNT)
//  rdIdx      : lookup index (fetch side), async read
//  rdTaken    : counter MSB at rdIdx, pre-update on same-cycle write
//  wrIdx      : update index (execute side)
//  wrTaken    : resolved direction used to train the counter
//  we         : update enable
module branch_history_table
  import branch_pkg::*;
#(
  parameter int unsigned ENTRIES = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [$clog2(ENTRIES)-1:0] rdIdx,
  output logic                       rdTaken,
  input  logic [$clog2(ENTRIES)-1:0] wrIdx,
  input  logic                       wrTaken,
  input  logic                       we
);

  bht_ctr_t ctrArray [ENTRIES];

  // Reset wins over a pending update in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(ENTRIES); i++) ctrArray[i] <= BHT_RESET_VAL;
    end else if (we) begin
      ctrArray[wrIdx] <= ctrNext(ctrArray[wrIdx], wrTaken);
    end
  end

  // Async read sees the stored value, so a same-cycle write is not forwarded.
  assign rdTaken = ctrArray[rdIdx][1];

endmodule

// File: rtl/branch_resolve_unit.sv
// Execute-stage branch resolver with a 2-bit dynamic predictor.
// Optional feature macro: BRU_PERF_CNT_EN (branch / mispredict perf counters).
//  clk, reset      : clock, synchronous active-high reset
//  PCF / PredTakenF: fetch-side lookup PC and its prediction
//  PredTakenE      : prediction carried down to E
//  BranchE, JumpE  : E instruction class; StallE holds E
//  TypeBranchE     : funct3 of the E branch
//  SrcAE, SrcBE    : forwarded operands
//  PCE, PCTargetE, PCPlus4E : E PC, taken target, fall-through
//  NeedBranchE, MispredictE, RedirectPCE, IllegalBranchE : combinational resolution
//  BranchCnt, MispredCnt : perf counters (tied to 0 without BRU_PERF_CNT_EN)
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned BHT_ENTRIES = 64,
  parameter int unsigned INDEX_LSB   = 2,
  parameter int unsigned PERF_CNT_W  = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [XLEN-1:0]       PCF,
  output logic                  PredTakenF,
  input  logic                  PredTakenE,
  input  logic                  BranchE,
  input  logic                  JumpE,
  input  logic                  StallE,
  input  logic [2:0]            TypeBranchE,
  input  logic [XLEN-1:0]       SrcAE,
  input  logic [XLEN-1:0]       SrcBE,
  input  logic [XLEN-1:0]       PCE,
  input  logic [XLEN-1:0]       PCTargetE,
  input  logic [XLEN-1:0]       PCPlus4E,
  output logic                  NeedBranchE,
  output logic                  MispredictE,
  output logic [XLEN-1:0]       RedirectPCE,
  output logic                  IllegalBranchE,
  output logic [PERF_CNT_W-1:0] BranchCnt,
  output logic [PERF_CNT_W-1:0] MispredCnt
);

  localparam int unsigned IDX_W = $clog2(BHT_ENTRIES);

  logic condRaw;
  logic cond;
  logic updateEn;
  logic unusedPcBits;

  // Branch condition from funct3; reserved encodings never take.
  always_comb begin
    condRaw = 1'b0;
    case (TypeBranchE)
      BEQ:     condRaw = (SrcAE == SrcBE);
      BNE:     condRaw = (SrcAE != SrcBE);
      BLT:     condRaw = ($signed(SrcAE) <  $signed(SrcBE));
      BGE:     condRaw = ($signed(SrcAE) >= $signed(SrcBE));
      BLTU:    condRaw = (SrcAE <  SrcBE);
      BGEU:    condRaw = (SrcAE >= SrcBE);
      default: condRaw = 1'b0;
    endcase
  end

  // Gating by BranchE keeps a don't-care funct3 from leaking into outputs or state.
  assign cond           = BranchE & condRaw;
  assign IllegalBranchE = BranchE & (TypeBranchE[2:1] == 2'b01);
  assign NeedBranchE    = cond | JumpE;
  assign MispredictE    = BranchE & ~StallE & (cond != PredTakenE) & ~IllegalBranchE;
  assign RedirectPCE    = cond ? PCTargetE : PCPlus4E;
  assign updateEn       = BranchE & ~StallE & ~IllegalBranchE;

  // Only the index field of each PC feeds the table.
  assign unusedPcBits = ^{PCF, PCE};

  branch_history_table #(
    .ENTRIES (BHT_ENTRIES)
  ) u_bht (
    .clk     (clk),
    .reset   (reset),
    .rdIdx   (PCF[INDEX_LSB +: IDX_W]),
    .rdTaken (PredTakenF),
    .wrIdx   (PCE[INDEX_LSB +: IDX_W]),
    .wrTaken (cond),
    .we      (updateEn)
  );

`ifdef BRU_PERF_CNT_EN
  // Free-running perf counters, wrapping naturally at full width.
  always_ff @(posedge clk) begin
    if (reset) begin
      BranchCnt  <= '0;
      MispredCnt <= '0;
    end else begin
      if (updateEn)    BranchCnt  <= BranchCnt  + PERF_CNT_W'(1);
      if (MispredictE) MispredCnt <= MispredCnt + PERF_CNT_W'(1);
    end
  end
`else
  assign BranchCnt  = '0;
  assign MispredCnt = '0;
`endif

endmodule
